lfsr_checker: RTL and testbench

//  Receive-side companion of the 12-bit LFSR random generator. It consumes a stream of
//  12-bit words, locks onto the generator sequence and then flags every word that

---
 rtl/lfsr_checker_if.sv | 8 +
 rtl/lfsr_checker.sv | 138 +++++++++++++
 tb/tb_lfsr_checker.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_checker_if.sv
// rtl/lfsr_checker_if.sv - sample stream carrying 12-bit generator words into the checker
interface lfsr_checker_if;
  logic        in_valid;
  logic [11:0] in_data;

  modport master (output in_valid, output in_data);
  modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - locks onto the 12-bit LFSR sequence and flags words that break it
module lfsr_checker #(
  parameter int LOCK_LEN   = 4,
  parameter int UNLOCK_LEN = 3,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_cnt,
  lfsr_checker_if.slave      s,
  output logic               locked,
  output logic               err_pulse,
  output logic [CNT_W-1:0]   err_count,
  output logic [11:0]        expected
);

  localparam int RUN_W  = $clog2(LOCK_LEN + 1);
  localparam int MISS_W = $clog2(UNLOCK_LEN + 1);
  localparam logic [RUN_W-1:0]  LOCK_LAST   = RUN_W'(LOCK_LEN - 1);
  localparam logic [MISS_W-1:0] UNLOCK_LAST = MISS_W'(UNLOCK_LEN - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [11:0]       pred_q, pred_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              locked_q, locked_d;
  logic              pulse_q, pulse_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_inc;
  logic              match;

  // Generator step; the all-ones state is swapped for zero so the sequence passes through 000.
  function automatic logic [11:0] lfsr_next(input logic [11:0] x);
    logic [11:0] y;
    y = {x[6] ^ x[4] ^ x[1] ^ x[0], x[11:1]};
    if (x == 12'h000) begin
      lfsr_next = 12'hFFF;
    end else if (y == 12'hFFF) begin
      lfsr_next = 12'h000;
    end else begin
      lfsr_next = y;
    end
  endfunction

  assign match = (s.in_data == pred_q);

  // Next-state: hunt/sync/locked tracking, flywheel prediction while locked, error counting.
  always_comb begin
    state_d  = state_q;
    pred_d   = pred_q;
    run_d    = run_q;
    miss_d   = miss_q;
    pulse_d  = 1'b0;
    cnt_d    = cnt_q;
    err_inc  = 1'b0;
    if (s.in_valid) begin
      case (state_q)
        HUNT: begin
          pred_d  = lfsr_next(s.in_data);
          run_d   = '0;
          state_d = SYNC;
        end
        SYNC: begin
          pred_d = lfsr_next(s.in_data);
          if (match) begin
            if (run_q == LOCK_LAST) begin
              state_d = LOCKED;
              miss_d  = '0;
              run_d   = '0;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            pred_d = lfsr_next(s.in_data);
            miss_d = '0;
          end else begin
            // Corrupted words are not trusted as a seed; keep stepping our own prediction.
            pred_d  = lfsr_next(pred_q);
            pulse_d = 1'b1;
            err_inc = 1'b1;
            if (miss_q == UNLOCK_LAST) begin
              state_d = HUNT;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    locked_d = (state_d == LOCKED);
    // A clear discards an error counted in the same cycle; the pulse still fires.
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (err_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and output registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      pred_q   <= '0;
      run_q    <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pred_q   <= pred_d;
      run_q    <= run_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = pulse_q;
  assign err_count = cnt_q;
  assign expected  = pred_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - directed and randomized check of lfsr_checker against a behavioural model
module tb_lfsr_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_cnt = 1'b0;
  logic        locked_a, pulse_a, locked_b, pulse_b;
  logic [15:0] count_a;
  logic [1:0]  count_b;
  logic [11:0] exp_a, exp_b;

  lfsr_checker_if bus ();

  lfsr_checker #(.LOCK_LEN(4), .UNLOCK_LEN(3), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .clr_cnt(clr_cnt), .s(bus),
    .locked(locked_a), .err_pulse(pulse_a), .err_count(count_a), .expected(exp_a));

  lfsr_checker #(.LOCK_LEN(4), .UNLOCK_LEN(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .clr_cnt(clr_cnt), .s(bus),
    .locked(locked_b), .err_pulse(pulse_b), .err_count(count_b), .expected(exp_b));

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  // Generator step computed arithmetically from the sequence definition.
  function automatic logic [11:0] m_next(input logic [11:0] x);
    int v, fb, y;
    v = int'(x);
    if (v == 0) return 12'hFFF;
    fb = ((v >> 6) ^ (v >> 4) ^ (v >> 1) ^ v) & 1;
    y  = (v >> 1) + fb * 2048;
    if (y == 4095) return 12'h000;
    return 12'(y);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: mode 0 hunting, 1 counting matches, 2 locked.
  int          m_mode = 0;
  int          m_run  = 0;
  int          m_miss = 0;
  logic [11:0] m_pred = 12'h000;
  logic        m_pulse = 1'b0;
  int          m_cnt_a = 0;
  int          m_cnt_b = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= 0; m_run <= 0; m_miss <= 0; m_pred <= 12'h000;
      m_pulse <= 1'b0; m_cnt_a <= 0; m_cnt_b <= 0;
    end else begin
      logic err;
      err = bus.in_valid && (m_mode == 2) && (bus.in_data != m_pred);
      m_pulse <= err;
      if (bus.in_valid) begin
        if (m_mode == 0) begin
          m_pred <= m_next(bus.in_data);
          m_run  <= 0;
          m_mode <= 1;
        end else if (m_mode == 1) begin
          m_pred <= m_next(bus.in_data);
          if (bus.in_data == m_pred) begin
            m_run <= m_run + 1;
            if (m_run + 1 == 4) begin m_mode <= 2; m_miss <= 0; end
          end else begin
            m_run <= 0;
          end
        end else begin
          if (!err) begin
            m_pred <= m_next(bus.in_data);
            m_miss <= 0;
          end else begin
            m_pred <= m_next(m_pred);
            m_miss <= m_miss + 1;
            if (m_miss + 1 == 3) m_mode <= 0;
          end
        end
      end
      if (clr_cnt) begin
        m_cnt_a <= 0; m_cnt_b <= 0;
      end else if (err) begin
        m_cnt_a <= (m_cnt_a == 65535) ? 65535 : m_cnt_a + 1;
        m_cnt_b <= (m_cnt_b == 3) ? 3 : m_cnt_b + 1;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("locked_a",   32'(locked_a), 32'(m_mode == 2));
      chk("pulse_a",    32'(pulse_a),  32'(m_pulse));
      chk("count_a",    32'(count_a),  32'(m_cnt_a));
      chk("expected_a", 32'(exp_a),    32'(m_pred));
      chk("locked_b",   32'(locked_b), 32'(m_mode == 2));
      chk("pulse_b",    32'(pulse_b),  32'(m_pulse));
      chk("count_b",    32'(count_b),  32'(m_cnt_b));
      chk("expected_b", 32'(exp_b),    32'(m_pred));
    end
  end

  task automatic drive(input logic v, input logic [11:0] d, input logic c, input logic r);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_data  = d;
    clr_cnt      = c;
    rst          = r;
  endtask

  task automatic settle();
    drive(1'b0, 12'h000, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  logic [11:0] g;

  task automatic send_good();
    drive(1'b1, g, 1'b0, 1'b0);
    g = m_next(g);
  endtask

  task automatic send_bad(input logic c);
    drive(1'b1, g ^ 12'h00F, c, 1'b0);
    g = m_next(g);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 12'h000;
    drive(1'b0, 12'h000, 1'b0, 1'b1);
    drive(1'b0, 12'h000, 1'b0, 1'b1);
    chk_en = 1'b1;
    settle();
    chk("rst_locked", 32'(locked_a), 32'd0);
    chk("rst_count",  32'(count_a),  32'd0);
    chk("rst_expect", 32'(exp_a),    32'd0);

    // Lock on 001,800,400,200,100.
    g = 12'h001;
    repeat (5) send_good();
    settle();
    chk("lock_locked", 32'(locked_a), 32'd1);
    chk("lock_expect", 32'(exp_a),    32'h080);
    chk("lock_count",  32'(count_a),  32'd0);

    // Single error then flywheel matches.
    drive(1'b1, 12'h081, 1'b0, 1'b0);
    drive(1'b1, 12'h040, 1'b0, 1'b0);
    drive(1'b1, 12'h820, 1'b0, 1'b0);
    settle();
    chk("single_count",  32'(count_a),  32'd1);
    chk("single_locked", 32'(locked_a), 32'd1);
    chk("single_expect", 32'(exp_a),    32'h410);

    // Gaps while locked.
    g = 12'h410;
    send_good();
    repeat (3) drive(1'b0, 12'h000, 1'b0, 1'b0);
    send_good();
    settle();

    // Wrap through 000/FFF via a fresh lock.
    drive(1'b0, 12'h000, 1'b0, 1'b1);
    g = 12'hFFE;
    repeat (5) send_good();
    settle();
    chk("wrap_locked", 32'(locked_a), 32'd1);
    chk("wrap_expect", 32'(exp_a),    32'h1FF);
    chk("wrap_count",  32'(count_a),  32'd0);

    // Loss of lock after three misses, then relock.
    repeat (3) send_bad(1'b0);
    settle();
    chk("loss_locked",  32'(locked_a), 32'd0);
    chk("loss_count",   32'(count_a),  32'd3);
    chk("loss_count_b", 32'(count_b),  32'd3);
    repeat (5) send_good();
    settle();
    chk("relock_locked", 32'(locked_a), 32'd1);
    chk("relock_count",  32'(count_a),  32'd3);

    // Saturation of the narrow counter and clear winning over an error.
    send_bad(1'b0);
    settle();
    chk("sat_count_a", 32'(count_a), 32'd4);
    chk("sat_count_b", 32'(count_b), 32'd3);
    send_good();
    send_bad(1'b1);
    settle();
    chk("clr_count", 32'(count_a), 32'd0);
    chk("clr_pulse", 32'(pulse_a), 32'd1);

    // Reset in the middle of synchronisation.
    drive(1'b0, 12'h000, 1'b0, 1'b1);
    g = 12'h001;
    repeat (3) send_good();
    drive(1'b0, 12'h000, 1'b0, 1'b1);
    settle();
    chk("midrst_locked", 32'(locked_a), 32'd0);
    chk("midrst_pulse",  32'(pulse_a),  32'd0);
    chk("midrst_count",  32'(count_a),  32'd0);
    chk("midrst_expect", 32'(exp_a),    32'd0);
    drive(1'b1, 12'h123, 1'b0, 1'b0);
    settle();
    chk("reseed_expect", 32'(exp_a), 32'h091);

    // Randomized traffic: gaps, corruption, reseeds, clears and resets.
    g = 12'($urandom);
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic v, c;
      logic [11:0] d;
      r = $urandom_range(0, 999);
      if (r < 4) begin
        drive(1'b0, 12'h000, 1'b0, 1'b1);
      end else begin
        if (r < 12) g = 12'($urandom);
        v = ($urandom_range(0, 3) != 0);
        c = ($urandom_range(0, 59) == 0);
        d = g;
        if ($urandom_range(0, 24) == 0) d = g ^ 12'($urandom_range(1, 4095));
        if (v) g = m_next(g);
        drive(v, d, c, 1'b0);
      end
    end
    settle();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
